// File: rtl/calc_pkg.sv
// Shared constants for the calculator: key codes, sequencer states and the
// one-hot operator encoding understood by the operator decoder and the ALU.
package calc_pkg;

    // Decoded key codes above the decimal digits 0-9
    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_EQ   = 4'd13;
    localparam logic [3:0] KEY_CLR  = 4'd14;
    localparam logic [3:0] KEY_RSVD = 4'd15;

    // One-hot operator select {C,B,A}
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    // Sequencer state encoding, also exported on the debug port
    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SHOW    = 3'd4
    } calc_state_e;

    // True for the decimal digit keys
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    // True for the three operator keys
    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
    endfunction

    // Operator key to one-hot select; non-operator keys map to no operator
    function automatic logic [2:0] key_to_op(input logic [3:0] k);
        logic [2:0] op;
        case (k)
            KEY_ADD: op = OP_ADD;
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal operand accumulator: shifts in one digit per push (val*10+digit)
// and silently drops digits once MAX_DIGITS have been entered.
module digit_accum #(
    parameter int MAX_DIGITS = 3,
    parameter int W          = 10,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          push,
    input  logic [3:0]    digit,
    output logic [W-1:0]  val,
    output logic [CW-1:0] count
);

    logic [W-1:0]  val_q, val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  base_val;
    logic [CW-1:0] base_cnt;
    logic [W+3:0]  shifted;

    // Next value: clear first (so clear+push restarts with a single digit),
    // then either a whole-value load or a saturating digit append
    always_comb begin
        base_val = clr ? '0 : val_q;
        base_cnt = clr ? '0 : cnt_q;
        shifted  = {4'd0, base_val} * (W + 4)'(10) + {{W{1'b0}}, digit};
        val_d    = base_val;
        cnt_d    = base_cnt;
        if (load) begin
            // A loaded value is a complete operand; further digits are refused
            val_d = load_val;
            cnt_d = CW'(MAX_DIGITS);
        end else if (push && (base_cnt < CW'(MAX_DIGITS))) begin
            val_d = shifted[W-1:0];
            cnt_d = base_cnt + CW'(1);
        end
    end

    // Operand and digit-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val   = val_q;
    assign count = cnt_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the calculator: collects operand A, operator and
// operand B, launches the ALU, waits for done, and holds the result for
// display and for chaining into the next calculation.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int W          = 10,
    parameter int RES_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    input  logic             alu_err,
    output logic [W-1:0]     opnd_a,
    output logic [W-1:0]     opnd_b,
    output logic [2:0]       op_sel,
    output logic             alu_start,
    output logic [RES_W-1:0] disp_val,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_o
);

    localparam int CW      = $clog2(MAX_DIGITS + 1);
    localparam int MAX_VAL = (10 ** MAX_DIGITS) - 1;

    localparam logic [2:0] S_ENTER_A = ST_ENTER_A;
    localparam logic [2:0] S_ENTER_B = ST_ENTER_B;
    localparam logic [2:0] S_EXEC    = ST_EXEC;
    localparam logic [2:0] S_WAIT    = ST_WAIT;
    localparam logic [2:0] S_SHOW    = ST_SHOW;

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_sel_q, op_sel_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic             clr_a, load_a, push_a;
    logic             clr_b, push_b;
    logic [W-1:0]     val_a, val_b;
    logic [CW-1:0]    cnt_a, cnt_b;

    logic             key_clr, key_dig, key_op, key_eq;
    logic             res_ok;
    logic             unused_cnt_a;

    // Key classification; the reserved code matches none of these
    always_comb begin
        key_clr = key_valid && (key_code == KEY_CLR);
        key_dig = key_valid && is_digit(key_code);
        key_op  = key_valid && is_op(key_code);
        key_eq  = key_valid && (key_code == KEY_EQ);
    end

    // A result can seed operand A only if it is error-free and fits the
    // decimal entry range (which also guarantees it fits in W bits)
    always_comb begin
        res_ok = !err_q
              && ((res_q >> W) == '0)
              && (res_q <= RES_W'(MAX_VAL));
    end

    // Sequencer next-state and datapath control
    always_comb begin
        state_d  = state_q;
        op_sel_d = op_sel_q;
        res_d    = res_q;
        err_d    = err_q;
        clr_a    = 1'b0;
        load_a   = 1'b0;
        push_a   = 1'b0;
        clr_b    = 1'b0;
        push_b   = 1'b0;

        if (key_clr) begin
            // Clear wins over everything, including a simultaneous alu_done
            state_d  = S_ENTER_A;
            op_sel_d = OP_NONE;
            res_d    = '0;
            err_d    = 1'b0;
            clr_a    = 1'b1;
            clr_b    = 1'b1;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (key_dig) begin
                        push_a = 1'b1;
                    end else if (key_op) begin
                        op_sel_d = key_to_op(key_code);
                        clr_b    = 1'b1;
                        state_d  = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (key_dig) begin
                        push_b = 1'b1;
                    end else if (key_op && (cnt_b == '0)) begin
                        // Operator can still be changed before B is entered
                        op_sel_d = key_to_op(key_code);
                    end else if (key_eq && (cnt_b != '0)) begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        res_d   = alu_result;
                        err_d   = err_q | alu_err;
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (key_dig) begin
                        // Fresh calculation starting with this digit
                        clr_a   = 1'b1;
                        push_a  = 1'b1;
                        clr_b   = 1'b1;
                        state_d = S_ENTER_A;
                    end else if (key_op) begin
                        if (res_ok) begin
                            load_a   = 1'b1;
                            op_sel_d = key_to_op(key_code);
                            clr_b    = 1'b1;
                            state_d  = S_ENTER_B;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_eq) begin
                        // Repeat the last operation on the previous result
                        if (res_ok) begin
                            load_a  = 1'b1;
                            state_d = S_EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_ENTER_A;
                end
            endcase
        end
    end

    // Sequencer state, operator, result and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ENTER_A;
            op_sel_q <= OP_NONE;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    digit_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .W          (W),
        .CW         (CW)
    ) u_acc_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_a),
        .load     (load_a),
        .load_val (res_q[W-1:0]),
        .push     (push_a),
        .digit    (key_code),
        .val      (val_a),
        .count    (cnt_a)
    );

    digit_accum #(
        .MAX_DIGITS (MAX_DIGITS),
        .W          (W),
        .CW         (CW)
    ) u_acc_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_b),
        .load     (1'b0),
        .load_val ('0),
        .push     (push_b),
        .digit    (key_code),
        .val      (val_b),
        .count    (cnt_b)
    );

    // Operand A's digit count only matters inside its own accumulator
    assign unused_cnt_a = ^cnt_a;

    // Display: the operand being typed, or the result once it is latched.
    // While the ALU runs the last typed entry (operand B) stays visible.
    always_comb begin
        case (state_q)
            S_ENTER_A: disp_val = RES_W'(val_a);
            S_SHOW:    disp_val = res_q;
            default:   disp_val = RES_W'(val_b);
        endcase
    end

    assign opnd_a    = val_a;
    assign opnd_b    = val_b;
    assign op_sel    = op_sel_q;
    assign alu_start = (state_q == S_EXEC);
    assign busy      = (state_q == S_EXEC) || (state_q == S_WAIT);
    assign err       = err_q;
    assign state_o   = state_q;

endmodule
